food_placer: RTL and testbench

- Sits directly downstream of random_number_generator in the snake game.
- On request, consumes the free-running 3-bit x/y random coordinates and rejects any cell occupied by the snake body.
- Commits one legal food position on the 8x8 grid.
- If random sampling fails MAX_TRIES times, falls back to a deterministic linear scan, so placement always terminates.

---
 rtl/snake_pkg.sv | 26 ++
 rtl/cell_lookup.sv | 16 +
 rtl/food_placer.sv | 126 ++++++++++++
 tb/tb_food_placer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game definitions.
// Contents:
//   - Grid geometry constants: GRID_BITS, IDX_BITS, CELLS.
//   - The food placer state encoding.
//   - cell_idx: packs a (y, x) coordinate pair into a linear cell index.
package snake_pkg;

  localparam int GRID_BITS = 3;
  localparam int IDX_BITS  = 2 * GRID_BITS;
  localparam int CELLS     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SCAN  = 2'd2
  } state_t;

  // Cell index is {y,x}: y selects the row of 8, x the column.
  function automatic logic [IDX_BITS-1:0] cell_idx(
    input logic [GRID_BITS-1:0] y,
    input logic [GRID_BITS-1:0] x
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/cell_lookup.sv
// Combinational 64:1 occupancy lookup.
// Ports:
//   occupied - snake body bitmap (bit = y*8 + x)
//   idx      - cell index to test
//   hit      - 1 when the addressed cell holds snake body
module cell_lookup
  import snake_pkg::*;
(
  input  logic [CELLS-1:0]    occupied,
  input  logic [IDX_BITS-1:0] idx,
  output logic                hit
);

  assign hit = occupied[idx];

endmodule

// File: rtl/food_placer.sv
// Food placer: picks a free cell for new food.
// Random (x,y) candidates are tried up to MAX_TRIES times. If all of them
// are rejected, a linear scan of every cell starts just after the last
// candidate, so placement always terminates.
// Ports:
//   clk, reset           - clock; synchronous active-low reset
//   rand_x, rand_y       - free-running random coordinates
//   occupied             - snake body bitmap (bit = y*8 + x)
//   place_req            - one-cycle placement request
//   food_x, food_y       - committed food position
//   food_valid           - committed position is legal
//   busy                 - search in progress (requests ignored)
//   board_full           - no free cell exists
module food_placer
  import snake_pkg::*;
#(
  parameter int MAX_TRIES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [GRID_BITS-1:0] rand_x,
  input  logic [GRID_BITS-1:0] rand_y,
  input  logic [CELLS-1:0]     occupied,
  input  logic                 place_req,
  output logic [GRID_BITS-1:0] food_x,
  output logic [GRID_BITS-1:0] food_y,
  output logic                 food_valid,
  output logic                 busy,
  output logic                 board_full
);

  localparam logic [7:0] TRY_LIMIT = 8'(MAX_TRIES);

  state_t              state;
  logic [IDX_BITS-1:0] cand;
  logic [IDX_BITS-1:0] scan_idx;
  logic [IDX_BITS-1:0] look_idx;
  logic [7:0]          try_cnt;
  logic [5:0]          scan_cnt;
  logic                hit;

  // Single lookup port shared by the random-check and scan paths.
  always_comb begin
    look_idx = cand;
    if (state == SCAN) begin
      look_idx = scan_idx;
    end else begin
      look_idx = cand;
    end
  end

  cell_lookup u_lookup (
    .occupied (occupied),
    .idx      (look_idx),
    .hit      (hit)
  );

  // Placement FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cand       <= 6'd0;
      scan_idx   <= 6'd0;
      try_cnt    <= 8'd0;
      scan_cnt   <= 6'd0;
      food_x     <= 3'd0;
      food_y     <= 3'd0;
      food_valid <= 1'b0;
      busy       <= 1'b0;
      board_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (place_req) begin
            cand       <= cell_idx(rand_y, rand_x);
            try_cnt    <= 8'd1;
            food_valid <= 1'b0;
            board_full <= 1'b0;
            busy       <= 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (!hit) begin
            food_y     <= cand[5:3];
            food_x     <= cand[2:0];
            food_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (try_cnt < TRY_LIMIT) begin
            cand    <= cell_idx(rand_y, rand_x);
            try_cnt <= try_cnt + 8'd1;
          end else begin
            // 6-bit add wraps 63 -> 0 naturally.
            scan_idx <= cand + 6'd1;
            scan_cnt <= 6'd0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (!hit) begin
            food_y     <= scan_idx[5:3];
            food_x     <= scan_idx[2:0];
            food_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (scan_cnt == 6'd63) begin
            // Every cell has been visited once and all are occupied.
            board_full <= 1'b1;
            food_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            scan_idx <= scan_idx + 6'd1;
            scan_cnt <= scan_cnt + 6'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// Directed self-checking bench for food_placer (MAX_TRIES = 8).
module tb_food_placer;

  logic        clk;
  logic        reset;
  logic [2:0]  rand_x;
  logic [2:0]  rand_y;
  logic [63:0] occupied;
  logic        place_req;
  logic [2:0]  food_x;
  logic [2:0]  food_y;
  logic        food_valid;
  logic        busy;
  logic        board_full;

  int tests;
  int fails;

  food_placer #(.MAX_TRIES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rand_x     (rand_x),
    .rand_y     (rand_y),
    .occupied   (occupied),
    .place_req  (place_req),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .busy       (busy),
    .board_full (board_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse place_req across one rising edge (E0); return at the following negedge.
  task automatic pulse_req();
    place_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    place_req = 1'b0;
  endtask

  // Advance edges until busy drops or the budget expires; cycles counts edges after E0.
  task automatic wait_done(input int max_cycles, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < max_cycles) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    place_req = 1'b1;
    occupied = 64'd0;
    rand_x = 3'd5;
    rand_y = 3'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (food_x !== 3'd0) begin fails++; $display("FAIL reset_food_x got %0d exp 0", food_x); end
    tests++; if (food_y !== 3'd0) begin fails++; $display("FAIL reset_food_y got %0d exp 0", food_y); end
    tests++; if (food_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", food_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (board_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", board_full); end
    place_req = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_free_first();
    int cyc;
    occupied = 64'd0;
    rand_x = 3'd5;
    rand_y = 3'd2;
    pulse_req();
    tests++; if (busy !== 1'b1 || food_valid !== 1'b0) begin
      fails++; $display("FAIL free_accept busy=%b valid=%b exp busy=1 valid=0", busy, food_valid);
    end
    wait_done(4, cyc);
    tests++; if (cyc !== 1) begin fails++; $display("FAIL free_latency got %0d exp 1", cyc); end
    tests++; if (food_x !== 3'd5 || food_y !== 3'd2 || food_valid !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL free_result got x=%0d y=%0d v=%b b=%b exp x=5 y=2 v=1 b=0", food_x, food_y, food_valid, busy);
    end
  endtask

  task automatic test_reject();
    int cyc;
    occupied = 64'd0;
    occupied[19] = 1'b1;
    rand_x = 3'd3;
    rand_y = 3'd2;
    pulse_req();
    rand_x = 3'd6;
    rand_y = 3'd4;
    wait_done(6, cyc);
    tests++; if (cyc !== 2) begin fails++; $display("FAIL reject_latency got %0d exp 2", cyc); end
    tests++; if (food_x !== 3'd6 || food_y !== 3'd4 || food_valid !== 1'b1) begin
      fails++; $display("FAIL reject_result got x=%0d y=%0d v=%b exp x=6 y=4 v=1", food_x, food_y, food_valid);
    end
  endtask

  // 8 tries, then scan 0 (occ), 1 (occ), 2 (free): 11 edges after E0.
  task automatic test_scan_wrap();
    int cyc;
    occupied = ~64'd0;
    occupied[2] = 1'b0;
    rand_x = 3'd7;
    rand_y = 3'd7;
    pulse_req();
    wait_done(40, cyc);
    tests++; if (cyc !== 11) begin fails++; $display("FAIL scan_latency got %0d exp 11", cyc); end
    tests++; if (food_x !== 3'd2 || food_y !== 3'd0 || food_valid !== 1'b1 || board_full !== 1'b0) begin
      fails++; $display("FAIL scan_result got x=%0d y=%0d v=%b f=%b exp x=2 y=0 v=1 f=0", food_x, food_y, food_valid, board_full);
    end
  endtask

  task automatic test_full_board();
    int cyc;
    occupied = ~64'd0;
    rand_x = 3'd1;
    rand_y = 3'd3;
    pulse_req();
    wait_done(200, cyc);
    tests++; if (cyc !== 72) begin fails++; $display("FAIL full_latency got %0d exp 72", cyc); end
    tests++; if (board_full !== 1'b1 || food_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL full_flags got f=%b v=%b b=%b exp f=1 v=0 b=0", board_full, food_valid, busy);
    end
    @(posedge clk);
    @(negedge clk);
    tests++; if (board_full !== 1'b1) begin fails++; $display("FAIL full_hold got %b exp 1", board_full); end
    occupied = 64'd0;
    pulse_req();
    tests++; if (board_full !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL full_clear got f=%b b=%b exp f=0 b=1", board_full, busy);
    end
    wait_done(4, cyc);
    tests++; if (food_x !== 3'd1 || food_y !== 3'd3 || food_valid !== 1'b1) begin
      fails++; $display("FAIL full_recover got x=%0d y=%0d v=%b exp x=1 y=3 v=1", food_x, food_y, food_valid);
    end
  endtask

  task automatic test_busy_req();
    int cyc;
    occupied = ~64'd0;
    occupied[2] = 1'b0;
    rand_x = 3'd7;
    rand_y = 3'd7;
    pulse_req();
    // 8 more edges puts the FSM in SCAN; a second request there must be dropped.
    repeat (8) @(posedge clk);
    @(negedge clk);
    rand_x = 3'd0;
    rand_y = 3'd5;
    pulse_req();
    wait_done(40, cyc);
    tests++; if (cyc !== 2) begin fails++; $display("FAIL busy_req_latency got %0d exp 2", cyc); end
    tests++; if (food_x !== 3'd2 || food_y !== 3'd0 || food_valid !== 1'b1) begin
      fails++; $display("FAIL busy_req_result got x=%0d y=%0d v=%b exp x=2 y=0 v=1", food_x, food_y, food_valid);
    end
    @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_req_queued got busy=%b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    // food currently at (2,0) from the previous test; start a long search.
    occupied = ~64'd0;
    rand_x = 3'd7;
    rand_y = 3'd7;
    pulse_req();
    repeat (10) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy got %b exp 1", busy); end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++; if (food_x !== 3'd0 || food_y !== 3'd0 || food_valid !== 1'b0 || busy !== 1'b0 || board_full !== 1'b0) begin
      fails++; $display("FAIL mid_reset got x=%0d y=%0d v=%b b=%b f=%b exp all 0", food_x, food_y, food_valid, busy, board_full);
    end
    reset = 1'b1;
    repeat (80) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0 || board_full !== 1'b0) begin
      fails++; $display("FAIL mid_discard got b=%b f=%b exp b=0 f=0", busy, board_full);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    place_req = 1'b0;
    rand_x = 3'd0;
    rand_y = 3'd0;
    occupied = 64'd0;
    @(negedge clk);
    test_reset();
    test_free_first();
    test_reject();
    test_scan_wrap();
    test_full_board();
    test_busy_req();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
